// File: rtl/dram_write_buffer.sv
// DRAM write buffer: a small circular FIFO between the pooled-output stage
// and the DRAM write port. Writes arrive with no backpressure. Each write is
// queued as {addr,data} and drained through a valid/ready request port. Once
// EXP_WRITES transfers have completed, the layer is finished and the buffer
// stays in DONE until reset.
//
// Handshake: a transfer completes on a rising edge where memValid=1 and
// memReady=1. While memValid=1 and memReady=0, memAddr and memData hold
// their value. Once memValid is raised it stays high until that transfer
// completes. The one exception is reset, which drops any pending data.
//
// dbgState encoding: 0 = IDLE, 1 = RUN, 2 = DONE.
module dram_write_buffer #(
  parameter int DEPTH      = 8,
  parameter int EXP_WRITES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inEn,
  input  logic [9:0]               inAddr,
  input  logic [63:0]              inData,
  output logic                     memValid,
  output logic [9:0]               memAddr,
  output logic [63:0]              memData,
  input  logic                     memReady,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     addrError,
  output logic                     done,
  output logic [1:0]               dbgState
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = $clog2(EXP_WRITES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [XW-1:0] EXP_CNT  = XW'(EXP_WRITES);
  localparam logic [XW-1:0] LAST_CNT = XW'(EXP_WRITES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [73:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XW-1:0]   xfer_q, xfer_d;
  logic            ovf_q, ovf_d;
  logic            aerr_q, aerr_d;
  logic [9:0]      prev_addr_q, prev_addr_d;
  logic            have_prev_q, have_prev_d;

  logic            pop;
  logic            push_ok;
  logic            last_pop;
  logic [73:0]     head;

  // Request side: the head entry is offered only while running with data
  assign head      = mem_q[rd_ptr_q];
  assign memValid  = (state_q == S_RUN) && (count_q != '0);
  assign memAddr   = memValid ? head[73:64] : '0;
  assign memData   = memValid ? head[63:0]  : '0;
  assign pop       = memValid && memReady;

  // A push fits if there is room now or the head leaves in the same cycle
  assign push_ok   = inEn && (state_q != S_DONE) &&
                     ((count_q != FULL_CNT) || pop);
  assign last_pop  = pop && (xfer_q == LAST_CNT);

  assign count     = count_q;
  assign full      = (count_q == FULL_CNT);
  assign overflow  = ovf_q;
  assign addrError = aerr_q;
  assign done      = (state_q == S_DONE);
  assign dbgState  = state_q;

  // FSM next-state: IDLE until the first accepted write, RUN until the
  // final transfer, then DONE until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (push_ok)  state_d = S_RUN;
      S_RUN:   if (last_pop) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath next-state: pointers, occupancy, transfer count, sticky flags
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    xfer_d      = xfer_q;
    ovf_d       = ovf_q;
    aerr_d      = aerr_q;
    prev_addr_d = prev_addr_q;
    have_prev_d = have_prev_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (xfer_q != EXP_CNT) xfer_d = xfer_q + XW'(1);
    end

    if (push_ok) begin
      wr_ptr_d    = wr_ptr_q + PW'(1);
      prev_addr_d = inAddr;
      have_prev_d = 1'b1;
      if (have_prev_q && (inAddr != prev_addr_q + 10'd1)) aerr_d = 1'b1;
    end

    // A write that is not accepted is lost: this covers a full FIFO and DONE
    if (inEn && !push_ok) ovf_d = 1'b1;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The final transfer flushes whatever is still queued
    if (last_pop) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      xfer_q      <= '0;
      ovf_q       <= 1'b0;
      aerr_q      <= 1'b0;
      prev_addr_q <= '0;
      have_prev_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      xfer_q      <= xfer_d;
      ovf_q       <= ovf_d;
      aerr_q      <= aerr_d;
      prev_addr_q <= prev_addr_d;
      have_prev_q <= have_prev_d;
    end
  end

  // Entry storage. It is not reset: the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {inAddr, inData};
  end

endmodule

// File: doc/dram_write_buffer.md
DRAM_WRITE_BUFFER -- requirements
Module: dram_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the number of FIFO entries (power of two).
REQ-002 SHALL have parameter EXP_WRITES, default 64, giving the number of memory transfers per layer.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-005 SHALL have port inEn, input, 1 bit, write strobe from the pooled-output stage; there is no backpressure.
REQ-006 SHALL have port inAddr, input, 10 bits, DRAM word address for the write.
REQ-007 SHALL have port inData, input, 64 bits, four packed 16-bit pooled results.
REQ-008 SHALL have port memValid, output, 1 bit, memory write request valid.
REQ-009 SHALL have port memAddr, output, 10 bits, memory write address.
REQ-010 SHALL have port memData, output, 64 bits, memory write data.
REQ-011 SHALL have port memReady, input, 1 bit, memory accepts the request.
REQ-012 SHALL have port count, output, 4 bits, current FIFO occupancy (0..DEPTH).
REQ-013 SHALL have port full, output, 1 bit, asserted when count == DEPTH.
REQ-014 SHALL have port overflow, output, 1 bit, sticky flag for a dropped write.
REQ-015 SHALL have port addrError, output, 1 bit, sticky flag for a non-sequential address.
REQ-016 SHALL have port done, output, 1 bit, sticky flag set when EXP_WRITES transfers are complete.

Function
REQ-017 SHALL store {inAddr,inData} in a DEPTH-entry circular FIFO, using wrapping read and write pointers plus an occupancy counter.
REQ-018 SHALL accept a push when inEn=1, state is not DONE, and either count<DEPTH or a pop occurs in the same cycle.
REQ-019 SHALL drop the write when inEn=1, full=1 and no pop occurs that cycle, and SHALL set overflow; count and pointers stay unchanged.
REQ-020 SHALL pop when memValid&&memReady; a simultaneous push and pop SHALL leave count unchanged.
REQ-021 SHALL present the FIFO head on memAddr/memData with memValid=(count!=0) and state RUN; a word pushed at edge N SHALL be visible on memValid at edge N+1 when the FIFO was empty (1-cycle latency).
REQ-022 SHALL keep memAddr and memData stable while memValid=1 and memReady=0.
REQ-023 SHALL set addrError when an accepted push other than the first since reset has inAddr != (previous accepted inAddr + 1) mod 1024.
REQ-024 SHALL count completed transfers in a counter wide enough for EXP_WRITES, and that counter SHALL saturate at EXP_WRITES.
REQ-025 SHALL implement FSM state IDLE: nothing accepted since reset and memValid=0; it SHALL move to RUN on the first accepted push.
REQ-026 SHALL implement FSM state RUN: it drains the FIFO and SHALL move to DONE on the pop that makes the transfer count equal to EXP_WRITES.
REQ-027 SHALL implement FSM state DONE: done=1 and memValid=0; any inEn SHALL be ignored and SHALL set overflow; the state is left only by reset.
REQ-028 SHALL pop any words still in the FIFO on DONE entry without transfer (flush); count SHALL read 0 in DONE.

Reset
REQ-029 SHALL, with rst=0 at a rising edge, clear pointers, count, the transfer counter, overflow, addrError and done, return the FSM to IDLE, and set memValid=0.
REQ-030 SHALL, when reset is asserted mid-transfer (memValid=1), drop pending data; memValid SHALL be 0 from the following cycle.
REQ-031 SHALL give memAddr and memData the value 0 after reset; inEn with rst=0 SHALL be ignored.

Verification
REQ-032 Bench SHALL cover this scenario: memReady=1; 4 pushes at addr 0x010..0x013 on consecutive cycles -> memValid high 1 cycle after the first push, 4 transfers in order, count returns to 0, addrError=0.
REQ-033 Bench SHALL cover this scenario: memReady=0; 9 pushes at addr 0..8 -> full=1 after the 8th, the 9th is dropped, overflow=1, count=8; then memReady=1 -> addr 0..7 transferred.
REQ-034 Bench SHALL cover this scenario: count=8, memReady=1, inEn=1 in the same cycle -> push accepted, count stays 8, overflow=0.
REQ-035 Bench SHALL cover this scenario: pushes to addr 0x3FE, 0x3FF, 0x000 -> addrError=0 (wrap legal); a next push to 0x005 -> addrError=1.
REQ-036 Bench SHALL cover this scenario: EXP_WRITES=4, 6 sequential pushes with memReady=1 -> done=1 after the 4th transfer, memValid=0, the remaining words are flushed, and a later inEn sets overflow.
REQ-037 Bench SHALL cover this scenario: rst=0 with 3 words queued and memReady=0 -> next cycle count=0, memValid=0, all flags 0, state IDLE.
